rom_line_buffer: RTL and testbench
==================================

Name: rom_line_buffer

Overview:
- Sits directly downstream of the SNES top-level ROM port, between the mapper-muxed ROM bus (ROM_ADDR/ROM_CE_N/ROM_OE_N/ROM_WORD/ROM_Q) and the SDRAM controller's read port.
- Holds one line of LINE_WORDS 16-bit words. Serves hits from registers.
- On a miss, fills the line with critical-word-first, wrapping word reads, so coprocessor mappers (GSU, SA1, CX4) see short ROM latency on sequential fetches.

Parameters:
- LINE_WORDS, 4, words per line; power of two, 2..8.
- ADDR_W, 24, byte address width of ROM_ADDR.

Ports:
- MCLK  in  1  system clock; all logic is rising-edge.
- RESET_N  in  1  asynchronous active-low reset.
- ROM_ADDR  in  24  byte address from the mapper mux.
- ROM_MASK  in  24  ROM size mask; applied to ROM_ADDR before lookup.
- ROM_CE_N  in  1  active-low chip enable.
- ROM_OE_N  in  1  active-low output enable.
- ROM_WORD  in  1  1 = 16-bit access; 0 = byte access.
- ROM_Q  out  16  read data to the mapper mux.
- ROM_BUSY  out  1  high while the requested data is not yet valid.
- INVALIDATE  in  1  synchronous pulse that clears the line (used on ROM reload).
- MEM_ADDR  out  23  SDRAM word address (byte address bits 23:1).
- MEM_RD  out  1  read request level.
- MEM_ACK  in  1  one-cycle pulse; MEM_DQ is valid in that cycle.
- MEM_DQ  in  16  SDRAM read data.

Behaviour:
- Reset values: ROM_Q=0, ROM_BUSY=0, MEM_RD=0, MEM_ADDR=0. Line valid bits all 0, tag 0, FSM in IDLE.
- Access: an access is active when ROM_CE_N=0 and ROM_OE_N=0. Effective address A = ROM_ADDR & ROM_MASK.
  - Tag = A[23:log2(LINE_WORDS)+1].
  - Word index = A[log2(LINE_WORDS):1].
- Hit: tag matches and the valid bit of the indexed word is set. ROM_Q updates on the next MCLK edge (1-cycle latency). ROM_BUSY stays 0.
- Output format:
  - ROM_WORD=1: ROM_Q = the stored word.
  - ROM_WORD=0: ROM_Q = {b,b}, where b = word[15:8] if A[0]=1, else word[7:0].
- ROM_Q holds its last value while no access is active.
- Miss: ROM_BUSY goes high combinationally in the same cycle.
  - If the FSM is IDLE: load the new tag, clear all valid bits, set start index = word index, go to FILL.
- FSM states:
  - IDLE: no request outstanding. A miss goes to REQ.
  - REQ: MEM_RD=1 and MEM_ADDR = {tag, idx}, both held stable until MEM_ACK.
    - On MEM_ACK: write MEM_DQ to word[idx], set valid[idx], go to GAP.
    - If idx equals the word currently requested by the CPU, also update ROM_Q from MEM_DQ in that same edge and drop ROM_BUSY the following cycle.
  - GAP: MEM_RD=0 for exactly 1 cycle. idx = (idx+1) mod LINE_WORDS.
    - If all LINE_WORDS words have been fetched, go to IDLE; otherwise go to REQ.
- Wrap-around: the fill order is start, start+1, ... modulo LINE_WORDS, never crossing into the next line.
- Mid-fill accesses:
  - Same tag, word already valid: served as a hit.
  - Same tag, word not yet valid: ROM_BUSY=1 until that word arrives.
  - Different tag: ROM_BUSY=1; the current fill completes, and the new miss is evaluated in IDLE.
  - Fills are never aborted.
- INVALIDATE:
  - In IDLE: clears all valid bits next cycle.
  - During a fill: the fill completes, then the valid bits are cleared.
  - If INVALIDATE coincides with a hit, the hit data is still returned that cycle.
- MEM_ACK outside REQ is ignored. This includes a stale ack after reset.
- Reset mid-fill: MEM_RD drops immediately (asynchronous) and all state returns to reset values.
- ROM_MASK change takes effect on the next lookup. No implicit invalidate.

Test Plan:
- Cold word miss: after reset, ROM_WORD=1, ROM_ADDR=0x000104, ROM_MASK=0xFFFFFF, ack data 0x1111/0x2222/0x3333/0x4444 → MEM_ADDR sequence 0x000082, 0x000083, 0x000080, 0x000081.
  - ROM_Q=0x1111 the cycle after the first ack; ROM_BUSY high 1 cycle before that ack until it.
  - Exactly 4 MEM_RD pulses, each followed by 1 low cycle.
- Hit after fill: read 0x000100 byte (ROM_WORD=0) → ROM_Q=0x3333 with ROM_BUSY=0, 1-cycle latency, no MEM_RD. Read 0x000101 byte → ROM_Q=0x3333.
  - Line refilled with word[0]=0xA55A: read 0x000101 byte → ROM_Q=0xA5A5.
- Mid-fill same line: start a miss at 0x000200, then request 0x000206 before its ack → ROM_BUSY stays 1 until the fourth ack. ROM_Q equals that ack's data.
- Mid-fill other line: during a fill of 0x000200, request 0x004000 → the fill finishes 4 words, then a new fill starts at MEM_ADDR 0x002000. No dropped or aborted request.
- Mask: ROM_MASK=0x0FFFFF, ROM_ADDR=0x300010 → MEM_ADDR=0x000008.
  - INVALIDATE pulse in IDLE, then a re-read of the same address → new fill issued.
- Reset mid-fill: assert RESET_N=0 while MEM_RD=1 → MEM_RD=0 immediately. After release, a stale MEM_ACK is ignored. The next access misses and refills.

Source files
------------

// File: rtl/rom_line_buffer.sv
// One-line ROM read buffer between the mapper ROM bus and the SDRAM read port; hits return in 1 cycle.
// Misses fill the whole line critical-word-first with wrap; ROM_BUSY stalls the mapper until its word lands.
module rom_line_buffer #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 24
) (
  input  logic              MCLK,
  input  logic              RESET_N,
  input  logic [ADDR_W-1:0] ROM_ADDR,
  input  logic [ADDR_W-1:0] ROM_MASK,
  input  logic              ROM_CE_N,
  input  logic              ROM_OE_N,
  input  logic              ROM_WORD,
  output logic [15:0]       ROM_Q,
  output logic              ROM_BUSY,
  input  logic              INVALIDATE,
  output logic [ADDR_W-2:0] MEM_ADDR,
  output logic              MEM_RD,
  input  logic              MEM_ACK,
  input  logic [15:0]       MEM_DQ
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - 1 - IDX_W;
  localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(LINE_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

  state_t                state;
  logic [TAG_W-1:0]      tag_r;
  logic [IDX_W-1:0]      idx_r;
  logic [IDX_W:0]        cnt_r;
  logic [LINE_WORDS-1:0] valid;
  logic                  inv_pend;
  logic [15:0]           line_q [LINE_WORDS];

  logic [ADDR_W-1:0] eff_addr;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  idx_inc;
  logic              access;
  logic              tag_match;
  logic              hit;
  logic              ack_take;
  logic              ack_fwd;

  assign eff_addr  = ROM_ADDR & ROM_MASK;
  assign req_tag   = eff_addr[ADDR_W-1 -: TAG_W];
  assign req_idx   = eff_addr[IDX_W:1];
  assign idx_inc   = idx_r + IDX_W'(1);
  assign access    = !ROM_CE_N && !ROM_OE_N;
  assign tag_match = (req_tag == tag_r);
  assign hit       = access && tag_match && valid[req_idx];
  assign ack_take  = (state == S_REQ) && MEM_ACK;
  // The word the mapper is stalled on is forwarded straight from the SDRAM bus.
  assign ack_fwd   = ack_take && access && tag_match && (req_idx == idx_r);
  assign ROM_BUSY  = access && !hit;

  function automatic logic [15:0] fmt(input logic [15:0] w, input logic word_acc, input logic hi_byte);
    logic [7:0] b;
    b = hi_byte ? w[15:8] : w[7:0];
    return word_acc ? w : {b, b};
  endfunction

  always_ff @(posedge MCLK) begin
    if (ack_take) line_q[idx_r] <= MEM_DQ;
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      tag_r    <= '0;
      idx_r    <= '0;
      cnt_r    <= '0;
      valid    <= '0;
      inv_pend <= 1'b0;
      ROM_Q    <= '0;
      MEM_RD   <= 1'b0;
      MEM_ADDR <= '0;
    end else begin
      if (hit)
        ROM_Q <= fmt(line_q[req_idx], ROM_WORD, eff_addr[0]);
      else if (ack_fwd)
        ROM_Q <= fmt(MEM_DQ, ROM_WORD, eff_addr[0]);

      case (state)
        S_IDLE: begin
          if (access && !hit) begin
            tag_r    <= req_tag;
            idx_r    <= req_idx;
            cnt_r    <= '0;
            valid    <= '0;
            inv_pend <= 1'b0;
            MEM_ADDR <= {req_tag, req_idx};
            MEM_RD   <= 1'b1;
            state    <= S_REQ;
          end else if (INVALIDATE) begin
            valid <= '0;
          end
        end
        S_REQ: begin
          if (INVALIDATE) inv_pend <= 1'b1;
          if (MEM_ACK) begin
            valid[idx_r] <= 1'b1;
            cnt_r        <= cnt_r + (IDX_W+1)'(1);
            MEM_RD       <= 1'b0;
            state        <= S_GAP;
          end
        end
        S_GAP: begin
          idx_r <= idx_inc;
          if (cnt_r == CNT_FULL) begin
            // Invalidates seen during the fill are applied only once it is complete.
            if (inv_pend || INVALIDATE) valid <= '0;
            inv_pend <= 1'b0;
            state    <= S_IDLE;
          end else begin
            if (INVALIDATE) inv_pend <= 1'b1;
            MEM_ADDR <= {tag_r, idx_inc};
            MEM_RD   <= 1'b1;
            state    <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_line_buffer.sv
// Directed bench for rom_line_buffer with a hand-driven SDRAM responder.
module tb_rom_line_buffer;

  logic        MCLK = 1'b0;
  logic        RESET_N;
  logic [23:0] ROM_ADDR;
  logic [23:0] ROM_MASK;
  logic        ROM_CE_N;
  logic        ROM_OE_N;
  logic        ROM_WORD;
  logic [15:0] ROM_Q;
  logic        ROM_BUSY;
  logic        INVALIDATE;
  logic [22:0] MEM_ADDR;
  logic        MEM_RD;
  logic        MEM_ACK;
  logic [15:0] MEM_DQ;

  int   total = 0;
  int   bad = 0;
  int   rd_pulses = 0;
  logic rd_q = 1'b0;

  rom_line_buffer dut (
    .MCLK(MCLK), .RESET_N(RESET_N), .ROM_ADDR(ROM_ADDR), .ROM_MASK(ROM_MASK),
    .ROM_CE_N(ROM_CE_N), .ROM_OE_N(ROM_OE_N), .ROM_WORD(ROM_WORD), .ROM_Q(ROM_Q),
    .ROM_BUSY(ROM_BUSY), .INVALIDATE(INVALIDATE), .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD),
    .MEM_ACK(MEM_ACK), .MEM_DQ(MEM_DQ)
  );

  always #5 MCLK = ~MCLK;

  always @(negedge MCLK) begin
    if (MEM_RD && !rd_q) rd_pulses++;
    rd_q = MEM_RD;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge MCLK);
    #2;
  endtask

  task automatic access(input logic [23:0] addr, input logic word);
    ROM_ADDR = addr;
    ROM_WORD = word;
    ROM_CE_N = 1'b0;
    ROM_OE_N = 1'b0;
  endtask

  task automatic idle_bus();
    ROM_CE_N = 1'b1;
    ROM_OE_N = 1'b1;
  endtask

  task automatic pulse_invalidate();
    INVALIDATE = 1'b1;
    tick();
    INVALIDATE = 1'b0;
  endtask

  // Wait for a read request, check its address, then ack it after lat cycles.
  task automatic serve(input logic [22:0] exp_addr, input logic [15:0] dat, input int lat, output int waited);
    int n;
    n = 0;
    while (MEM_RD !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    waited = n;
    total++;
    if (MEM_RD !== 1'b1) begin
      bad++;
      $display("FAIL serve_rd_timeout: MEM_RD=%b after %0d cycles, required 1 (addr %h)", MEM_RD, n, exp_addr);
    end else begin
      total++;
      if (MEM_ADDR !== exp_addr) begin
        bad++;
        $display("FAIL serve_addr: MEM_ADDR=%h, required %h", MEM_ADDR, exp_addr);
      end
      repeat (lat) tick();
      MEM_DQ  = dat;
      MEM_ACK = 1'b1;
      tick();
      MEM_ACK = 1'b0;
      total++;
      if (MEM_RD !== 1'b0) begin
        bad++;
        $display("FAIL serve_gap: MEM_RD=%b after ack, required 0", MEM_RD);
      end
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; ROM_ADDR = '0; ROM_MASK = 24'hFFFFFF; ROM_CE_N = 1'b1; ROM_OE_N = 1'b1;
    ROM_WORD = 1'b1; INVALIDATE = 1'b0; MEM_ACK = 1'b0; MEM_DQ = '0;
    repeat (3) @(posedge MCLK);
    #2;
    total++;
    if (ROM_Q !== 16'h0 || ROM_BUSY !== 1'b0 || MEM_RD !== 1'b0 || MEM_ADDR !== 23'h0) begin
      bad++;
      $display("FAIL reset_vals: Q=%h BUSY=%b RD=%b ADDR=%h, required 0 0 0 0", ROM_Q, ROM_BUSY, MEM_RD, MEM_ADDR);
    end
    @(negedge MCLK) RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_cold_miss();
    int w;
    int p0;
    p0 = rd_pulses;
    access(24'h000104, 1'b1);
    #1;
    total++;
    if (ROM_BUSY !== 1'b1) begin bad++; $display("FAIL cold_busy_miss: BUSY=%b, required 1", ROM_BUSY); end
    tick();
    total++;
    if (ROM_BUSY !== 1'b1) begin bad++; $display("FAIL cold_busy_ack_cycle: BUSY=%b, required 1", ROM_BUSY); end
    serve(23'h000082, 16'h1111, 0, w);
    total++;
    if (ROM_Q !== 16'h1111 || ROM_BUSY !== 1'b0) begin
      bad++;
      $display("FAIL cold_first_word: Q=%h BUSY=%b, required 1111 0", ROM_Q, ROM_BUSY);
    end
    serve(23'h000083, 16'h2222, 0, w);
    total++;
    if (w != 1) begin bad++; $display("FAIL cold_gap_len: low cycles=%0d, required 1", w); end
    serve(23'h000080, 16'h3333, 1, w);
    serve(23'h000081, 16'h4444, 0, w);
    idle_bus();
    repeat (3) tick();
    total++;
    if (MEM_RD !== 1'b0 || rd_pulses - p0 != 4) begin
      bad++;
      $display("FAIL cold_pulse_count: RD=%b pulses=%0d, required 0 4", MEM_RD, rd_pulses - p0);
    end
  endtask

  task automatic test_hit();
    int p0;
    p0 = rd_pulses;
    access(24'h000100, 1'b0);
    #1;
    total++;
    if (ROM_BUSY !== 1'b0 || ROM_Q !== 16'h1111) begin
      bad++;
      $display("FAIL hit_comb: BUSY=%b Q=%h, required 0 1111", ROM_BUSY, ROM_Q);
    end
    tick();
    total++;
    if (ROM_Q !== 16'h3333) begin bad++; $display("FAIL hit_byte_lo: Q=%h, required 3333", ROM_Q); end
    access(24'h000101, 1'b0);
    tick();
    total++;
    if (ROM_Q !== 16'h3333) begin bad++; $display("FAIL hit_byte_hi: Q=%h, required 3333", ROM_Q); end
    access(24'h000102, 1'b1);
    tick();
    total++;
    if (ROM_Q !== 16'h4444) begin bad++; $display("FAIL hit_word1: Q=%h, required 4444", ROM_Q); end
    idle_bus();
    tick();
    total++;
    if (rd_pulses != p0) begin bad++; $display("FAIL hit_no_mem_rd: pulses=%0d, required 0", rd_pulses - p0); end
  endtask

  task automatic test_refill_bytes();
    int w;
    pulse_invalidate();
    access(24'h000101, 1'b0);
    #1;
    total++;
    if (ROM_BUSY !== 1'b1) begin bad++; $display("FAIL refill_busy: BUSY=%b, required 1", ROM_BUSY); end
    serve(23'h000080, 16'hA55A, 1, w);
    total++;
    if (ROM_Q !== 16'hA5A5) begin bad++; $display("FAIL refill_byte_hi: Q=%h, required a5a5", ROM_Q); end
    serve(23'h000081, 16'hB0B1, 0, w);
    serve(23'h000082, 16'hC2C3, 0, w);
    serve(23'h000083, 16'hD4D5, 0, w);
    access(24'h000100, 1'b0);
    tick();
    total++;
    if (ROM_Q !== 16'h5A5A) begin bad++; $display("FAIL refill_byte_lo: Q=%h, required 5a5a", ROM_Q); end
    access(24'h000102, 1'b1);
    INVALIDATE = 1'b1;
    tick();
    INVALIDATE = 1'b0;
    total++;
    if (ROM_Q !== 16'hB0B1) begin bad++; $display("FAIL inv_hit_data: Q=%h, required b0b1", ROM_Q); end
    #1;
    total++;
    if (ROM_BUSY !== 1'b1) begin bad++; $display("FAIL inv_busy_after: BUSY=%b, required 1", ROM_BUSY); end
    idle_bus();
    tick();
  endtask

  task automatic test_midfill_same();
    int w;
    access(24'h000200, 1'b1);
    tick();
    ROM_ADDR = 24'h000206;
    for (int i = 0; i < 4; i++) begin
      serve(23'(32'h100 + i), 16'(32'hC000 + i), 1, w);
      if (i < 3) begin
        total++;
        if (ROM_BUSY !== 1'b1 || ROM_Q !== 16'hB0B1) begin
          bad++;
          $display("FAIL same_wait_%0d: BUSY=%b Q=%h, required 1 b0b1", i, ROM_BUSY, ROM_Q);
        end
      end
    end
    total++;
    if (ROM_BUSY !== 1'b0 || ROM_Q !== 16'hC003) begin
      bad++;
      $display("FAIL same_last_word: BUSY=%b Q=%h, required 0 c003", ROM_BUSY, ROM_Q);
    end
    idle_bus();
    tick();
  endtask

  task automatic test_midfill_other();
    int w;
    pulse_invalidate();
    access(24'h000200, 1'b1);
    tick();
    ROM_ADDR = 24'h004000;
    for (int i = 0; i < 4; i++) begin
      serve(23'(32'h100 + i), 16'(32'h7000 + i), 0, w);
      total++;
      if (ROM_BUSY !== 1'b1 || ROM_Q !== 16'hC003) begin
        bad++;
        $display("FAIL other_wait_%0d: BUSY=%b Q=%h, required 1 c003", i, ROM_BUSY, ROM_Q);
      end
    end
    serve(23'h002000, 16'hD000, 0, w);
    total++;
    if (ROM_BUSY !== 1'b0 || ROM_Q !== 16'hD000) begin
      bad++;
      $display("FAIL other_new_fill: BUSY=%b Q=%h, required 0 d000", ROM_BUSY, ROM_Q);
    end
    for (int i = 1; i < 4; i++) serve(23'(32'h2000 + i), 16'(32'hD000 + i), 0, w);
    idle_bus();
    tick();
  endtask

  task automatic test_mask_invalidate();
    int w;
    ROM_MASK = 24'h0FFFFF;
    access(24'h300010, 1'b1);
    serve(23'h000008, 16'hE008, 0, w);
    total++;
    if (ROM_Q !== 16'hE008) begin bad++; $display("FAIL mask_data: Q=%h, required e008", ROM_Q); end
    for (int i = 1; i < 4; i++) serve(23'(32'h8 + i), 16'(32'hE008 + i), 0, w);
    idle_bus();
    tick();
    pulse_invalidate();
    access(24'h300010, 1'b1);
    #1;
    total++;
    if (ROM_BUSY !== 1'b1) begin bad++; $display("FAIL mask_inv_busy: BUSY=%b, required 1", ROM_BUSY); end
    serve(23'h000008, 16'hF008, 0, w);
    total++;
    if (ROM_Q !== 16'hF008) begin bad++; $display("FAIL mask_refill: Q=%h, required f008", ROM_Q); end
    for (int i = 1; i < 4; i++) serve(23'(32'h8 + i), 16'(32'hF008 + i), 0, w);
    idle_bus();
    ROM_MASK = 24'hFFFFFF;
    repeat (2) tick();
  endtask

  task automatic test_reset_midfill();
    int w;
    access(24'h000400, 1'b1);
    tick();
    total++;
    if (MEM_RD !== 1'b1) begin bad++; $display("FAIL rst_pre_rd: RD=%b, required 1", MEM_RD); end
    RESET_N = 1'b0;
    #1;
    total++;
    if (MEM_RD !== 1'b0) begin bad++; $display("FAIL rst_rd_async: RD=%b, required 0", MEM_RD); end
    idle_bus();
    #1;
    total++;
    if (ROM_Q !== 16'h0 || ROM_BUSY !== 1'b0 || MEM_ADDR !== 23'h0) begin
      bad++;
      $display("FAIL rst_midfill_vals: Q=%h BUSY=%b ADDR=%h, required 0 0 0", ROM_Q, ROM_BUSY, MEM_ADDR);
    end
    @(negedge MCLK) RESET_N = 1'b1;
    tick();
    MEM_DQ  = 16'hDEAD;
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    total++;
    if (MEM_RD !== 1'b0 || ROM_Q !== 16'h0) begin
      bad++;
      $display("FAIL stale_ack: RD=%b Q=%h, required 0 0", MEM_RD, ROM_Q);
    end
    access(24'h000000, 1'b1);
    #1;
    total++;
    if (ROM_BUSY !== 1'b1) begin bad++; $display("FAIL stale_ack_miss: BUSY=%b, required 1", ROM_BUSY); end
    serve(23'h000000, 16'h0123, 0, w);
    total++;
    if (ROM_Q !== 16'h0123) begin bad++; $display("FAIL post_reset_fill: Q=%h, required 0123", ROM_Q); end
    for (int i = 1; i < 4; i++) serve(23'(i), 16'(32'h0123 + i), 0, w);
    idle_bus();
    tick();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_refill_bytes();
    test_midfill_same();
    test_midfill_other();
    test_mask_invalidate();
    test_reset_midfill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
